ms_wb_splitter: RTL and testbench
=================================

// Module: ms_wb_splitter
// PURPOSE
//  Parametrised Wishbone classic 1-master -> NSLV-slave splitter with registered response path and
//  per-transaction timeout. Sits between the Caravel wbs_* port and the user peripherals (tmr32,
//  uart, psram, dac8, adc8, ...). Replaces combinational stb/ack/dat muxing: a hung slave can no
//  longer stall the management core, and unmapped accesses get a defined reply.
// PARAMETERS
//  NSLV     5             number of slave ports
//  DEC_LSB  16            LSB of the address decode field m_adr_i[DEC_LSB+3:DEC_LSB]
//  SLV_ID   {4'hA,4'h8,4'h4,4'h2,4'h0}  packed NSLV*4; decode value of slave k = SLV_ID[4k+3:4k]
//  TMO_W    8             timeout counter width
//  TMO_CYC  8'd255        BUSY cycles without slave ack before timeout (1..2^TMO_W-1)
//  DEF_DAT  32'hDEADBEEF  read data returned on miss or timeout
// PORTS
//  clk_i     in   1         bus clock; all logic on rising edge
//  rst_i     in   1         synchronous, active-high reset
//  m_cyc_i   in   1         master cycle
//  m_stb_i   in   1         master strobe
//  m_we_i    in   1         master write enable (fans out to slaves unregistered)
//  m_sel_i   in   4         byte selects (fan out unregistered)
//  m_adr_i   in   32        address (fans out unregistered; decoded here)
//  m_dat_i   in   32        write data (fans out unregistered)
//  m_ack_o   out  1         registered ack, 1-cycle pulse
//  m_err_o   out  1         registered error, 1-cycle pulse (0 unless WB_SPLIT_ERR_EN)
//  m_dat_o   out  32        registered read data, valid while m_ack_o/m_err_o high
//  s_stb_o   out  NSLV      one-hot slave strobe
//  s_ack_i   in   NSLV      slave acks
//  s_dat_i   in   NSLV*32   slave read data, slave k at [32k+31:32k]
//  tmo_o     out  1         1-cycle pulse on every timeout
// BEHAVIOUR
//  Reset: state IDLE; m_ack_o/m_err_o/tmo_o=0, s_stb_o=0, m_dat_o=0, timeout counter=0.
//  IDLE: on m_cyc_i&m_stb_i decode m_adr_i field vs SLV_ID; lowest matching k wins.
//   hit  -> latch k, s_stb_o[k]=1 next cycle, clear counter, go BUSY.
//   miss -> go RESP with m_dat_o=DEF_DAT, kind=MISS; no s_stb_o asserted.
//  BUSY: s_stb_o[k] held high; counter +1 per cycle.
//   s_ack_i[k]=1 -> s_stb_o=0 next cycle, capture s_dat_i[k] into m_dat_o, m_ack_o=1 next cycle, go IDLE.
//   counter==TMO_CYC and no ack -> s_stb_o=0, m_dat_o=DEF_DAT, tmo_o=1, kind=TMO response next cycle, go IDLE.
//   ack and timeout in same cycle -> ack wins, no tmo_o.
//   m_cyc_i=0 (abort) -> s_stb_o=0, no ack/err, go IDLE; counter cleared.
//   s_ack_i of non-selected slaves ignored.
//  RESP (miss path only): response pulse for exactly 1 cycle, then IDLE.
//  Latency: hit = slave ack cycle + 1; miss = 2 cycles after stb seen; timeout = TMO_CYC+2 after stb.
//  Response pulse is one cycle; m_stb_i still high in the cycle after the pulse starts a new transaction
//  (back-to-back supported, 1 idle cycle minimum between responses).
//  Late s_ack_i after timeout/abort: ignored in IDLE.
//  Reset mid-transaction: immediate return to reset values; no response issued.
// CONFIGURATION
//  WB_SPLIT_ERR_EN defined: miss and timeout respond with m_err_o=1, m_ack_o=0, m_dat_o=DEF_DAT.
//  WB_SPLIT_ERR_EN undefined: m_err_o tied 0; miss and timeout respond with m_ack_o=1, m_dat_o=DEF_DAT
//   (legacy-compatible). tmo_o behaves identically in both builds.
// TESTING
//  Read 0x3002_0000, slave 1 acks 3 cycles after stb with 0x1234_5678 -> s_stb_o=5'b00010, m_ack_o 1 cycle later, m_dat_o=0x1234_5678.
//  Read 0x3006_0000 (unmapped) -> s_stb_o stays 0; 2 cycles later 1-cycle ack (or err w/ macro), m_dat_o=0xDEADBEEF.
//  Write 0x3008_0000, slave 3 never acks, TMO_CYC=255 -> tmo_o and response at cycle 257, s_stb_o drops; late ack ignored.
//  Slave 0 ack in same cycle counter hits TMO_CYC -> m_ack_o with slave data, tmo_o stays 0.
//  m_cyc_i dropped 2 cycles into BUSY, and separately rst_i in BUSY -> s_stb_o=0 next cycle, no ack/err, IDLE.
//  Back-to-back reads slave 0 then slave 4, each acking in 1 cycle -> two clean ack pulses, correct data each.

Source files
------------

// File: rtl/ms_wb_splitter_if.sv
// Wishbone classic bus bundle between the management master, the splitter and NSLV slaves.
// The slave modport is the splitter's view; the master modport drives the master and slave sides.
interface ms_wb_splitter_if #(
  parameter int NSLV = 5
);
  logic               m_cyc_i;
  logic               m_stb_i;
  logic               m_we_i;
  logic [3:0]         m_sel_i;
  logic [31:0]        m_adr_i;
  logic [31:0]        m_dat_i;
  logic               m_ack_o;
  logic               m_err_o;
  logic [31:0]        m_dat_o;
  logic [NSLV-1:0]    s_stb_o;
  logic [NSLV-1:0]    s_ack_i;
  logic [NSLV*32-1:0] s_dat_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    output m_ack_o, m_err_o, m_dat_o, s_stb_o,
    input  s_ack_i, s_dat_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    input  m_ack_o, m_err_o, m_dat_o, s_stb_o,
    output s_ack_i, s_dat_i
  );
endinterface

// File: rtl/ms_wb_splitter.sv
// Wishbone 1->NSLV splitter: registered strobe/response path with per-transaction timeout.
// Define WB_SPLIT_ERR_EN to answer misses and timeouts with m_err_o instead of m_ack_o.
module ms_wb_splitter #(
  parameter int                NSLV    = 5,
  parameter int                DEC_LSB = 16,
  parameter logic [NSLV*4-1:0] SLV_ID  = {4'hA, 4'h8, 4'h4, 4'h2, 4'h0},
  parameter int                TMO_W   = 8,
  parameter logic [TMO_W-1:0]  TMO_CYC = 8'd255,
  parameter logic [31:0]       DEF_DAT = 32'hDEADBEEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  ms_wb_splitter_if.slave bus,
  output logic            tmo_o
);
  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

`ifdef WB_SPLIT_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    sel_q, sel_d, hit_idx;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [NSLV-1:0]  stb_q, stb_d, hit_oh;
  logic             ack_q, ack_d, err_q, err_d, tmo_q, tmo_d;
  logic [31:0]      dat_q, dat_d;
  logic [3:0]       field;
  logic             hit, req, sack, tmo_hit;
  logic             unused_ok;

  assign field   = bus.m_adr_i[DEC_LSB+3:DEC_LSB];
  // The master still holds stb during the response pulse; don't re-decode it.
  assign req     = bus.m_cyc_i & bus.m_stb_i & ~(ack_q | err_q);
  assign sack    = bus.s_ack_i[sel_q];
  assign tmo_hit = (cnt_q == TMO_CYC);

  // Descending scan so the lowest matching slave is the one that sticks.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_oh  = '0;
    for (int k = NSLV-1; k >= 0; k--) begin
      if (field == SLV_ID[4*k +: 4]) begin
        hit       = 1'b1;
        hit_idx   = IW'(k);
        hit_oh    = '0;
        hit_oh[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      stb_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      dat_q   <= dat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req) begin
        if (hit) begin
          state_d = BUSY;
          sel_d   = hit_idx;
          cnt_d   = '0;
        end else begin
          state_d = RESP;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (!bus.m_cyc_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (sack || tmo_hit) begin
          state_d = IDLE;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered-output next values; ack beats timeout when both land together.
  always_comb begin
    stb_d = '0;
    ack_d = 1'b0;
    err_d = 1'b0;
    tmo_d = 1'b0;
    dat_d = dat_q;
    case (state_q)
      IDLE: if (req && hit) stb_d = hit_oh;
      BUSY: begin
        if (!bus.m_cyc_i) begin
          stb_d = '0;
        end else if (sack) begin
          ack_d = 1'b1;
          dat_d = bus.s_dat_i[32*int'(sel_q) +: 32];
        end else if (tmo_hit) begin
          tmo_d = 1'b1;
          ack_d = ~ERR_EN;
          err_d = ERR_EN;
          dat_d = DEF_DAT;
        end else begin
          stb_d = stb_q;
        end
      end
      RESP: begin
        ack_d = ~ERR_EN;
        err_d = ERR_EN;
        dat_d = DEF_DAT;
      end
      default: ;
    endcase
  end

  assign bus.m_ack_o = ack_q;
  assign bus.m_dat_o = dat_q;
  assign bus.s_stb_o = stb_q;
  assign tmo_o       = tmo_q;
`ifdef WB_SPLIT_ERR_EN
  assign bus.m_err_o = err_q;
`else
  assign bus.m_err_o = 1'b0;
`endif

  // we/sel/wdat and the non-decode address bits only fan out to the slaves.
  assign unused_ok = ^{bus.m_we_i, bus.m_sel_i, bus.m_dat_i, bus.m_adr_i};
endmodule

// File: tb/tb_ms_wb_splitter.sv
// Scoreboard bench for ms_wb_splitter: a transaction-level model predicts each response
// (cycle, kind, data) and a monitor pops and compares whenever the DUT answers.
module tb_ms_wb_splitter;
  localparam int          NSLV  = 5;
  localparam int          TMO   = 255;
  localparam int          NEVER = 100000;
  localparam logic [31:0] DEF   = 32'hDEADBEEF;
`ifdef WB_SPLIT_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  typedef struct {
    int          cyc;
    logic        ack;
    logic        err;
    logic        tmo;
    logic [31:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic tmo_o;
  always #5 clk = ~clk;

  ms_wb_splitter_if #(.NSLV(NSLV)) bus();
  ms_wb_splitter dut (.clk_i(clk), .rst_i(rst_i), .bus(bus), .tmo_o(tmo_o));

  exp_t        q[$];
  exp_t        me;
  int          cyc_cnt = 0;
  int          n_chk = 0, n_err = 0;
  int          exp_tgt = -1;
  int          last_r = -10;
  int          dly_a[NSLV];
  int          scnt[NSLV];
  logic [31:0] sdat[NSLV];
  logic [3:0]  ids[NSLV] = '{4'h0, 4'h2, 4'h4, 4'h8, 4'hA};

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_cnt);
    end
  endtask

  function automatic int decode(input logic [31:0] adr);
    for (int k = 0; k < NSLV; k++) if (adr[19:16] == ids[k]) return k;
    return -1;
  endfunction

  // Slave models: selected slave acks after its programmed delay; idle slaves spray noise acks.
  always @(negedge clk) begin
    for (int k = 0; k < NSLV; k++) begin
      if (bus.s_stb_o[k] === 1'b1) begin
        bus.s_ack_i[k] = (scnt[k] == dly_a[k]);
        scnt[k]++;
      end else begin
        scnt[k] = 0;
        bus.s_ack_i[k] = ($urandom_range(3) == 0);
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc < cyc_cnt) begin
      n_chk++; n_err++;
      $display("FAIL resp_missing: no response seen, required at cycle %0d", q[0].cyc);
      void'(q.pop_front());
    end
    if (bus.s_stb_o !== '0 && bus.s_stb_o !== 'x)
      chk("s_stb_onehot", 32'(bus.s_stb_o), (exp_tgt >= 0) ? (32'd1 << exp_tgt) : 32'd0);
    if (bus.m_ack_o === 1'b1 || bus.m_err_o === 1'b1 || tmo_o === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL resp_unexpected: ack=%b err=%b tmo=%b with none required (cycle %0d)",
                 bus.m_ack_o, bus.m_err_o, tmo_o, cyc_cnt);
      end else begin
        me = q.pop_front();
        chk("resp_cycle", cyc_cnt, me.cyc);
        chk("m_ack", 32'(bus.m_ack_o), 32'(me.ack));
        chk("m_err", 32'(bus.m_err_o), 32'(me.err));
        chk("tmo", 32'(tmo_o), 32'(me.tmo));
        chk("m_dat", bus.m_dat_o, me.dat);
      end
    end
  end

  task automatic wait_to(input int c);
    while (cyc_cnt < c) @(negedge clk);
  endtask

  // Called on a negedge; the request is sampled at the first edge the splitter is free.
  task automatic run_txn(input logic [31:0] adr, input logic we, input int dly, input bit keep);
    int   tgt, t0;
    exp_t e;
    tgt = decode(adr);
    t0  = (cyc_cnt > last_r) ? cyc_cnt : last_r + 1;
    bus.m_cyc_i = 1'b1; bus.m_stb_i = 1'b1; bus.m_adr_i = adr; bus.m_we_i = we;
    bus.m_sel_i = 4'($urandom); bus.m_dat_i = $urandom;
    for (int k = 0; k < NSLV; k++) begin
      sdat[k] = $urandom;
      bus.s_dat_i[32*k +: 32] = sdat[k];
    end
    exp_tgt = tgt;
    if (tgt < 0) begin
      e.cyc = t0 + 2; e.ack = ~ERR; e.err = ERR; e.tmo = 1'b0; e.dat = DEF;
    end else begin
      dly_a[tgt] = dly;
      if (dly <= TMO) begin
        e.cyc = t0 + 2 + dly; e.ack = 1'b1; e.err = 1'b0; e.tmo = 1'b0; e.dat = sdat[tgt];
      end else begin
        e.cyc = t0 + 2 + TMO; e.ack = ~ERR; e.err = ERR; e.tmo = 1'b1; e.dat = DEF;
      end
    end
    q.push_back(e);
    last_r = e.cyc;
    wait_to(e.cyc);
    if (!keep) begin bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0; end
  endtask

  // Hold slave 2 busy, then either drop cyc (abort) or pulse reset two cycles into BUSY.
  task automatic kill_test(input bit use_rst);
    int t0;
    @(negedge clk);
    t0 = cyc_cnt;
    dly_a[2] = NEVER; exp_tgt = 2;
    bus.m_cyc_i = 1'b1; bus.m_stb_i = 1'b1; bus.m_adr_i = 32'h3004_0000; bus.m_we_i = 1'b0;
    if (use_rst) begin
      wait_to(t0 + 2);
      chk("busy_stb", 32'(bus.s_stb_o), 32'h4);
      rst_i = 1'b1;
      wait_to(t0 + 3);
      chk("rst_stb", 32'(bus.s_stb_o), 32'h0);
      chk("rst_dat", bus.m_dat_o, 32'h0);
      rst_i = 1'b0; bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0;
      last_r = t0 + 3;
    end else begin
      wait_to(t0 + 3);
      bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0;
      wait_to(t0 + 4);
      chk("abort_stb", 32'(bus.s_stb_o), 32'h0);
      last_r = t0 + 3;
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    logic [3:0]  fld;
    logic [31:0] adr;
    int          dly;
    bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0; bus.m_we_i = 1'b0; bus.m_sel_i = '0;
    bus.m_adr_i = '0; bus.m_dat_i = '0; bus.s_ack_i = '0; bus.s_dat_i = '0;
    for (int k = 0; k < NSLV; k++) begin dly_a[k] = 0; scnt[k] = 0; sdat[k] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(bus.m_ack_o), 32'h0);
    chk("rst_err", 32'(bus.m_err_o), 32'h0);
    chk("rst_tmo", 32'(tmo_o), 32'h0);
    chk("rst_s_stb", 32'(bus.s_stb_o), 32'h0);
    chk("rst_m_dat", bus.m_dat_o, 32'h0);
    rst_i = 1'b0;
    @(negedge clk);

    run_txn(32'h3002_0000, 1'b0, 2, 1'b0);
    @(negedge clk);
    run_txn(32'h3006_0000, 1'b0, 0, 1'b0);
    @(negedge clk);
    run_txn(32'h3008_0000, 1'b1, NEVER, 1'b0);
    chk("tmo_stb_drop", 32'(bus.s_stb_o), 32'h0);
    repeat (4) @(negedge clk);
    run_txn(32'h3000_0000, 1'b0, TMO, 1'b0);
    @(negedge clk);
    run_txn(32'h3000_0000, 1'b0, TMO + 1, 1'b0);
    kill_test(1'b0);
    kill_test(1'b1);
    run_txn(32'h3000_0000, 1'b0, 0, 1'b1);
    run_txn(32'h300A_0000, 1'b0, 0, 1'b0);
    @(negedge clk);

    for (int i = 0; i < 80; i++) begin
      fld = ($urandom_range(9) < 7) ? ids[$urandom_range(NSLV-1)] : 4'($urandom);
      adr = {12'h300, fld, 16'($urandom)};
      case ($urandom_range(39))
        0:       dly = NEVER;
        1:       dly = TMO;
        2,3,4,5: dly = $urandom_range(20, 5);
        default: dly = $urandom_range(4);
      endcase
      run_txn(adr, 1'($urandom), dly, 1'($urandom));
      if (bus.m_cyc_i == 1'b0) repeat ($urandom_range(3)) @(negedge clk);
    end
    bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
